// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage. It holds the PC, issues req/ack word
//            fetches, and buffers one instruction for the decoder. Optional
//            counters are enabled with the macro FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  func
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_pending_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        w_accept;

  assign imem_req  = (r_state == S_FETCH) && !rst;
  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign opcode    = r_out_instr[31:26];
  assign func      = r_out_instr[5:0];

  // An ack loads the buffer only if nothing has invalidated the request.
  assign w_accept = (r_state == S_FETCH) && imem_ack && !r_kill && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_pending_pc <= 32'h0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= 32'h0;
      r_out_pc     <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            if (r_kill) begin
              r_pc   <= redirect_valid ? redirect_pc : r_pending_pc;
              r_kill <= 1'b0;
            end else if (redirect_valid) begin
              r_pc <= redirect_pc;
            end else begin
              r_out_instr <= imem_rdata;
              r_out_pc    <= r_pc;
              r_out_valid <= 1'b1;
              r_pc        <= r_pc + PC_STEP;
              r_state     <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // The request in flight cannot be withdrawn, so its address stays.
            // The redirect target is parked until the ack arrives.
            r_kill       <= 1'b1;
            r_pending_pc <= redirect_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_out_valid <= 1'b0;
            r_pc        <= redirect_pc;
            r_state     <= S_FETCH;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (w_accept)
        r_fetch_count <= r_fetch_count + 32'd1;
      if (r_out_valid && !out_ready)
        r_stall_count <= r_stall_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
